// File: rtl/gsu_pixel_cache.sv
// Plot-stage pixel cache: gathers PLOT writes for one 8-pixel tile row and flushes it as bitplane bytes.
// Optional macro GSU_PLOT_TRANSPARENT_EN: colour-0 plots (masked to the active plane count) are accepted but not written.
module gsu_pixel_cache #(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 plot_valid,
    output logic                 plot_ready,
    input  logic [COORD_W-1:0]   plot_x,
    input  logic [COORD_W-1:0]   plot_y,
    input  logic [COLOR_W-1:0]   plot_color,
    input  logic [1:0]           bpp_mode,
    input  logic                 flush_req,
    output logic                 flush_valid,
    input  logic                 flush_ready,
    output logic [COORD_W-4:0]   flush_tile,
    output logic [COORD_W-1:0]   flush_y,
    output logic [2:0]           flush_plane,
    output logic [7:0]           flush_data,
    output logic [7:0]           flush_mask,
    output logic                 flush_last,
    output logic [7:0]           valid_flags,
    output logic                 busy
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [7:0]           flags_q, flags_d;
    logic [COORD_W-4:0]   tile_q, tile_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [2:0]           plane_q, plane_d;
    logic [2:0]           last_plane_q, last_plane_d;
    logic                 flush_valid_q, flush_valid_d;
    logic [COLOR_W-1:0]   color_q [8];
    logic [COLOR_W-1:0]   color_d [8];

    logic       nonempty;
    logic       mismatch;
    logic       transparent;
    logic [2:0] col;
    logic [2:0] bpp_last;

    assign nonempty = |flags_q;
    assign mismatch = (plot_x[COORD_W-1:3] != tile_q) || (plot_y != y_q);
    assign col      = plot_x[2:0];

    always_comb begin
        case (bpp_mode)
            2'b00:   bpp_last = 3'd1;
            2'b01:   bpp_last = 3'd3;
            default: bpp_last = 3'd7;
        endcase
    end

`ifdef GSU_PLOT_TRANSPARENT_EN
    logic [COLOR_W-1:0] bpp_mask;
    always_comb begin
        case (bpp_mode)
            2'b00:   bpp_mask = COLOR_W'(2'b11);
            2'b01:   bpp_mask = COLOR_W'(4'hF);
            default: bpp_mask = '1;
        endcase
    end
    assign transparent = ((plot_color & bpp_mask) == '0);
`else
    assign transparent = 1'b0;
`endif

    // A transparent plot never writes, so a tile mismatch cannot stall it.
    always_comb begin
        plot_ready = 1'b0;
        if (state_q == IDLE) begin
            plot_ready = !flush_req && (transparent || !(nonempty && mismatch));
        end
    end

    always_comb begin
        state_d       = state_q;
        flags_d       = flags_q;
        tile_d        = tile_q;
        y_d           = y_q;
        plane_d       = plane_q;
        last_plane_d  = last_plane_q;
        flush_valid_d = flush_valid_q;
        color_d       = color_q;
        case (state_q)
            IDLE: begin
                if (plot_valid && plot_ready) begin
                    if (!transparent) begin
                        color_d[col]        = plot_color;
                        flags_d[3'd7 - col] = 1'b1;
                        if (!nonempty) begin
                            tile_d = plot_x[COORD_W-1:3];
                            y_d    = plot_y;
                        end
                        if (flags_d == 8'hFF) begin
                            state_d       = FLUSH;
                            plane_d       = 3'd0;
                            last_plane_d  = bpp_last;
                            flush_valid_d = 1'b1;
                        end
                    end
                end else if (nonempty && (flush_req || (plot_valid && mismatch && !transparent))) begin
                    state_d       = FLUSH;
                    plane_d       = 3'd0;
                    last_plane_d  = bpp_last;
                    flush_valid_d = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_ready) begin
                    if (plane_q == last_plane_q) begin
                        state_d       = IDLE;
                        flags_d       = 8'h00;
                        plane_d       = 3'd0;
                        flush_valid_d = 1'b0;
                    end else begin
                        plane_d = plane_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            flags_q       <= 8'h00;
            tile_q        <= '0;
            y_q           <= '0;
            plane_q       <= 3'd0;
            last_plane_q  <= 3'd0;
            flush_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                color_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            tile_q        <= tile_d;
            y_q           <= y_d;
            plane_q       <= plane_d;
            last_plane_q  <= last_plane_d;
            flush_valid_q <= flush_valid_d;
            for (int i = 0; i < 8; i++) begin
                color_q[i] <= color_d[i];
            end
        end
    end

    // Column c lands on bit 7-c; unwritten columns read as zero.
    always_comb begin
        flush_data = 8'h00;
        if (flush_valid_q) begin
            for (int c = 0; c < 8; c++) begin
                flush_data[7-c] = flags_q[7-c] & color_q[c][plane_q];
            end
        end
    end

    assign flush_valid = flush_valid_q;
    assign flush_tile  = tile_q;
    assign flush_y     = y_q;
    assign flush_plane = plane_q;
    assign flush_mask  = flags_q;
    assign flush_last  = flush_valid_q && (plane_q == last_plane_q);
    assign valid_flags = flags_q;
    assign busy        = (state_q == FLUSH);

endmodule

// File: tb/tb_gsu_pixel_cache.sv
// Self-checking bench for gsu_pixel_cache: scoreboarded flush beats plus per-scenario checks.
module tb_gsu_pixel_cache;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       plot_valid = 1'b0;
    logic       plot_ready;
    logic [7:0] plot_x = 8'd0;
    logic [7:0] plot_y = 8'd0;
    logic [7:0] plot_color = 8'd0;
    logic [1:0] bpp_mode = 2'b01;
    logic       flush_req = 1'b0;
    logic       flush_valid;
    logic       flush_ready = 1'b1;
    logic [4:0] flush_tile;
    logic [7:0] flush_y;
    logic [2:0] flush_plane;
    logic [7:0] flush_data;
    logic [7:0] flush_mask;
    logic       flush_last;
    logic [7:0] valid_flags;
    logic       busy;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [32:0] exp_q[$];

    gsu_pixel_cache #(.COORD_W(8), .COLOR_W(8)) dut (
        .clk(clk), .reset(reset),
        .plot_valid(plot_valid), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
        .bpp_mode(bpp_mode), .flush_req(flush_req),
        .flush_valid(flush_valid), .flush_ready(flush_ready),
        .flush_tile(flush_tile), .flush_y(flush_y), .flush_plane(flush_plane),
        .flush_data(flush_data), .flush_mask(flush_mask), .flush_last(flush_last),
        .valid_flags(valid_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [32:0] pack_beat(input logic [2:0] p, input logic [7:0] d,
                                              input logic [7:0] m, input logic l,
                                              input logic [4:0] t, input logic [7:0] yy);
        return {p, d, m, l, t, yy};
    endfunction

    task automatic push_beat(input logic [2:0] p, input logic [7:0] d, input logic [7:0] m,
                             input logic l, input logic [4:0] t, input logic [7:0] yy);
        exp_q.push_back(pack_beat(p, d, m, l, t, yy));
    endtask

    // Scoreboard: every accepted beat is popped and compared.
    always @(negedge clk) begin
        logic [32:0] got, exp;
        #2;
        if (!reset && flush_valid && flush_ready) begin
            got = pack_beat(flush_plane, flush_data, flush_mask, flush_last, flush_tile, flush_y);
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected got plane=%0d data=%h mask=%h last=%b, expected no beat",
                         flush_plane, flush_data, flush_mask, flush_last);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp)
                    $display("FAIL beat got {plane,data,mask,last,tile,y}=%h expected %h", got, exp);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic do_plot(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
        int n = 0;
        plot_valid = 1'b1; plot_x = x; plot_y = y; plot_color = c;
        #1;
        while (!plot_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk_cnt++;
        if (!plot_ready) $display("FAIL plot_accept_timeout x=%0d y=%0d got ready=0 expected 1", x, y);
        else pass_cnt++;
        @(negedge clk);
        plot_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int cycles);
        int n = 0;
        while ((busy || flush_valid) && n < 200) begin
            @(negedge clk); n++;
        end
        cycles = n;
        chk_cnt++;
        if (busy || flush_valid) $display("FAIL %s_idle_timeout got busy=%b expected 0", name, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        chk_cnt++;
        if ({plot_ready, flush_valid, flush_last, busy} !== 4'b1000)
            $display("FAIL reset_ctrl got {ready,fv,last,busy}=%b expected 1000",
                     {plot_ready, flush_valid, flush_last, busy});
        else pass_cnt++;
        chk_cnt++;
        if ({valid_flags, flush_plane, flush_data, flush_tile, flush_y} !== 32'h0)
            $display("FAIL reset_data got flags=%h plane=%0d data=%h tile=%0d y=%0d expected all 0",
                     valid_flags, flush_plane, flush_data, flush_tile, flush_y);
        else pass_cnt++;
    endtask

    task automatic test_fill_row();
        int cyc;
        bpp_mode = 2'b01;
        push_beat(3'd0, 8'h55, 8'hFF, 1'b0, 5'd0, 8'd5);
        push_beat(3'd1, 8'h33, 8'hFF, 1'b0, 5'd0, 8'd5);
        push_beat(3'd2, 8'h0F, 8'hFF, 1'b0, 5'd0, 8'd5);
        push_beat(3'd3, 8'h00, 8'hFF, 1'b1, 5'd0, 8'd5);
        for (int x = 0; x < 8; x++) do_plot(8'(x), 8'd5, 8'(x));
        chk_cnt++;
        if (!(flush_valid && busy && flush_plane == 3'd0))
            $display("FAIL fill_first_beat got fv=%b busy=%b plane=%0d expected 1 1 0",
                     flush_valid, busy, flush_plane);
        else pass_cnt++;
        wait_idle("fill", cyc);
        chk_cnt++;
        if (cyc != 4) $display("FAIL fill_flush_cycles got %0d expected 4", cyc);
        else pass_cnt++;
        chk_cnt++;
        if (valid_flags !== 8'h00 || exp_q.size() != 0)
            $display("FAIL fill_after got flags=%h pending=%0d expected 00 0", valid_flags, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_partial_flush();
        int cyc;
        bpp_mode = 2'b00;
        pulse_flush();
        chk_cnt++;
        if (busy !== 1'b0 || flush_valid !== 1'b0)
            $display("FAIL empty_flush_ignored got busy=%b fv=%b expected 0 0", busy, flush_valid);
        else pass_cnt++;
        do_plot(8'd2, 8'd9, 8'd3);
        chk_cnt++;
        if (valid_flags !== 8'h20) $display("FAIL partial_flag_latency got %h expected 20", valid_flags);
        else pass_cnt++;
        do_plot(8'd6, 8'd9, 8'd1);
        push_beat(3'd0, 8'h22, 8'h22, 1'b0, 5'd0, 8'd9);
        push_beat(3'd1, 8'h20, 8'h22, 1'b1, 5'd0, 8'd9);
        plot_valid = 1'b1; plot_x = 8'd4; plot_y = 8'd9; plot_color = 8'd2;
        flush_req = 1'b1;
        #1;
        chk_cnt++;
        if (plot_ready !== 1'b0) $display("FAIL flush_priority got ready=%b expected 0", plot_ready);
        else pass_cnt++;
        @(negedge clk);
        flush_req = 1'b0; plot_valid = 1'b0;
        wait_idle("partial", cyc);
        chk_cnt++;
        if (cyc != 2 || valid_flags !== 8'h00)
            $display("FAIL partial_after got cycles=%0d flags=%h expected 2 00", cyc, valid_flags);
        else pass_cnt++;
    endtask

    task automatic test_tile_change();
        int cyc;
        bpp_mode = 2'b10;
        do_plot(8'd3, 8'd0, 8'hFF);
        for (int p = 0; p < 8; p++) push_beat(3'(p), 8'h10, 8'h10, p == 7, 5'd0, 8'd0);
        plot_valid = 1'b1; plot_x = 8'd8; plot_y = 8'd0; plot_color = 8'h22;
        #1;
        chk_cnt++;
        if (plot_ready !== 1'b0) $display("FAIL tile_hold got ready=%b expected 0", plot_ready);
        else pass_cnt++;
        do_plot(8'd8, 8'd0, 8'h22);
        chk_cnt++;
        if (valid_flags !== 8'h80 || flush_tile !== 5'd1 || exp_q.size() != 0)
            $display("FAIL tile_after got flags=%h tile=%0d pending=%0d expected 80 1 0",
                     valid_flags, flush_tile, exp_q.size());
        else pass_cnt++;
        bpp_mode = 2'b00;
        push_beat(3'd0, 8'h00, 8'h80, 1'b0, 5'd1, 8'd0);
        push_beat(3'd1, 8'h80, 8'h80, 1'b1, 5'd1, 8'd0);
        pulse_flush();
        bpp_mode = 2'b10;
        wait_idle("tile_clean", cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        int n = 0;
        bpp_mode = 2'b01;
        do_plot(8'd16, 8'd3, 8'h0F);
        do_plot(8'd17, 8'd3, 8'h05);
        push_beat(3'd0, 8'hC0, 8'hC0, 1'b0, 5'd2, 8'd3);
        push_beat(3'd1, 8'h80, 8'hC0, 1'b0, 5'd2, 8'd3);
        push_beat(3'd2, 8'hC0, 8'hC0, 1'b0, 5'd2, 8'd3);
        push_beat(3'd3, 8'h80, 8'hC0, 1'b1, 5'd2, 8'd3);
        pulse_flush();
        while (!(flush_valid && flush_plane == 3'd1) && n < 20) begin
            @(negedge clk); n++;
        end
        flush_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (!flush_valid || flush_plane !== 3'd1 || flush_data !== 8'h80)
                $display("FAIL bp_stable k=%0d got fv=%b plane=%0d data=%h expected 1 1 80",
                         k, flush_valid, flush_plane, flush_data);
            else pass_cnt++;
        end
        flush_ready = 1'b1;
        wait_idle("bp", cyc);
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL bp_pending got %0d expected 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_flush();
        int cyc;
        bpp_mode = 2'b01;
        do_plot(8'd40, 8'd7, 8'd3);
        push_beat(3'd0, 8'h80, 8'h80, 1'b0, 5'd5, 8'd7);
        pulse_flush();
        @(negedge clk);
        reset = 1'b1; flush_ready = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (flush_valid !== 1'b0 || valid_flags !== 8'h00 || plot_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_abort got fv=%b flags=%h ready=%b busy=%b expected 0 00 1 0",
                     flush_valid, valid_flags, plot_ready, busy);
        else pass_cnt++;
        reset = 1'b0; flush_ready = 1'b1;
        do_plot(8'd7, 8'd0, 8'd2);
        chk_cnt++;
        if (valid_flags !== 8'h01) $display("FAIL reset_fresh_plot got %h expected 01", valid_flags);
        else pass_cnt++;
        bpp_mode = 2'b00;
        push_beat(3'd0, 8'h00, 8'h01, 1'b0, 5'd0, 8'd0);
        push_beat(3'd1, 8'h01, 8'h01, 1'b1, 5'd0, 8'd0);
        pulse_flush();
        wait_idle("reset_clean", cyc);
    endtask

    task automatic test_transparent();
        int cyc;
        bpp_mode = 2'b01;
        do_plot(8'd1, 8'd0, 8'h10);
`ifdef GSU_PLOT_TRANSPARENT_EN
        chk_cnt++;
        if (valid_flags !== 8'h00) $display("FAIL transp_flags got %h expected 00", valid_flags);
        else pass_cnt++;
        pulse_flush();
        for (int k = 0; k < 2; k++) begin
            chk_cnt++;
            if (busy !== 1'b0 || flush_valid !== 1'b0)
                $display("FAIL transp_no_flush got busy=%b fv=%b expected 0 0", busy, flush_valid);
            else pass_cnt++;
            @(negedge clk);
        end
`else
        chk_cnt++;
        if (valid_flags !== 8'h40) $display("FAIL zero_colour_flags got %h expected 40", valid_flags);
        else pass_cnt++;
        for (int p = 0; p < 4; p++) push_beat(3'(p), 8'h00, 8'h40, p == 3, 5'd0, 8'd0);
        pulse_flush();
        wait_idle("zero_colour", cyc);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_fill_row();
        test_partial_flush();
        test_tile_change();
        test_backpressure();
        test_reset_mid_flush();
        test_transparent();
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL final_pending got %0d expected 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
